parking_gate_ctrl: RTL and testbench

Downstream consumer of the two Debouncer instances (entry and exit loop sensors) in the smart parking system. Detects vehicle arrival and departure edges on the debounced sensor levels. Maintains the lot occupancy count against a fixed capacity and drives the entry and exit barrier-open commands with a post-vehicle hold time. Runs in the 40 MHz system clock domain.

---
 rtl/parking_pkg.sv | 15 +
 rtl/parking_gate_fsm.sv | 81 ++++++++
 rtl/parking_gate_ctrl.sv | 92 +++++++++
 tb/tb_parking_gate_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking gate controller and
// the Debouncer top-level integration.
package parking_pkg;

    typedef enum logic [1:0] {
        GATE_IDLE = 2'd0,
        GATE_OPEN = 2'd1,
        GATE_HOLD = 2'd2
    } gate_state_e;

    localparam int DEFAULT_CAPACITY         = 8;
    localparam int DEFAULT_COUNT_W          = 4;
    localparam int DEFAULT_GATE_HOLD_CYCLES = 4000;

endpackage

// File: rtl/parking_gate_fsm.sv
// One barrier direction: sensor edge detection, gate state machine and
// post-vehicle hold timer. The parent decides whether a rising edge is accepted.
module parking_gate_fsm
    import parking_pkg::*;
#(
    parameter int GATE_HOLD_CYCLES = DEFAULT_GATE_HOLD_CYCLES,
    parameter int HOLD_W           = $clog2(GATE_HOLD_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_i,
    input  logic accept_i,
    output logic rise_o,
    output logic gate_open_o
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(GATE_HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic              sensor_q;
    gate_state_e       state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              gate_open_q;

    assign rise_o      = sensor_i & ~sensor_q;
    assign gate_open_o = gate_open_q;

    // Next-state and hold-counter logic for the barrier.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            GATE_IDLE: begin
                if (accept_i) state_d = GATE_OPEN;
                else          state_d = GATE_IDLE;
            end
            GATE_OPEN: begin
                if (accept_i) begin
                    state_d = GATE_OPEN;
                end else if (!sensor_i) begin
                    state_d = GATE_HOLD;
                    hold_d  = HOLD_LOAD;
                end else begin
                    state_d = GATE_OPEN;
                end
            end
            GATE_HOLD: begin
                // A newly accepted vehicle restarts the open phase; a refused one does not.
                if (accept_i) begin
                    state_d = GATE_OPEN;
                    hold_d  = HOLD_ZERO;
                end else if (hold_q == HOLD_ZERO) begin
                    state_d = GATE_IDLE;
                end else begin
                    hold_d  = hold_q - HOLD_ONE;
                end
            end
            default: begin
                state_d = GATE_IDLE;
                hold_d  = HOLD_ZERO;
            end
        endcase
    end

    // State, edge-detect and registered gate command; reset captures the live sensor level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sensor_q    <= sensor_i;
            state_q     <= GATE_IDLE;
            hold_q      <= HOLD_ZERO;
            gate_open_q <= 1'b0;
        end else begin
            sensor_q    <= sensor_i;
            state_q     <= state_d;
            hold_q      <= hold_d;
            gate_open_q <= (state_d != GATE_IDLE);
        end
    end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking lot occupancy tracking with entry/exit acceptance arbitration and
// the two barrier controllers.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int CAPACITY         = DEFAULT_CAPACITY,
    parameter int COUNT_W          = DEFAULT_COUNT_W,
    parameter int GATE_HOLD_CYCLES = DEFAULT_GATE_HOLD_CYCLES,
    parameter int HOLD_W           = $clog2(GATE_HOLD_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               entry_sensor,
    input  logic               exit_sensor,
    output logic [COUNT_W-1:0] occupancy,
    output logic               full,
    output logic               empty,
    output logic               entry_gate_open,
    output logic               exit_gate_open,
    output logic               entry_reject,
    output logic               exit_error
);

    localparam logic [COUNT_W-1:0] CAP_C  = COUNT_W'(CAPACITY);
    localparam logic [COUNT_W-1:0] ZERO_C = COUNT_W'(0);
    localparam logic [COUNT_W-1:0] ONE_C  = COUNT_W'(1);

    logic               entry_rise_s, exit_rise_s;
    logic               arr_ok_s, dep_ok_s;
    logic [COUNT_W-1:0] occupancy_q, occupancy_d;
    logic               full_q, empty_q, entry_reject_q, exit_error_q;

    parking_gate_fsm #(
        .GATE_HOLD_CYCLES (GATE_HOLD_CYCLES),
        .HOLD_W           (HOLD_W)
    ) u_entry_gate (
        .clk         (clk),
        .reset       (reset),
        .sensor_i    (entry_sensor),
        .accept_i    (arr_ok_s),
        .rise_o      (entry_rise_s),
        .gate_open_o (entry_gate_open)
    );

    parking_gate_fsm #(
        .GATE_HOLD_CYCLES (GATE_HOLD_CYCLES),
        .HOLD_W           (HOLD_W)
    ) u_exit_gate (
        .clk         (clk),
        .reset       (reset),
        .sensor_i    (exit_sensor),
        .accept_i    (dep_ok_s),
        .rise_o      (exit_rise_s),
        .gate_open_o (exit_gate_open)
    );

    // Both decisions look at the pre-update count, so simultaneous events never wrap it.
    always_comb begin
        arr_ok_s    = entry_rise_s && (occupancy_q != CAP_C);
        dep_ok_s    = exit_rise_s  && (occupancy_q != ZERO_C);
        occupancy_d = occupancy_q;
        case ({arr_ok_s, dep_ok_s})
            2'b10:   occupancy_d = occupancy_q + ONE_C;
            2'b01:   occupancy_d = occupancy_q - ONE_C;
            default: occupancy_d = occupancy_q;
        endcase
    end

    // Registered count, status flags and one-cycle fault pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy_q    <= ZERO_C;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            entry_reject_q <= 1'b0;
            exit_error_q   <= 1'b0;
        end else begin
            occupancy_q    <= occupancy_d;
            full_q         <= (occupancy_d == CAP_C);
            empty_q        <= (occupancy_d == ZERO_C);
            entry_reject_q <= entry_rise_s && !arr_ok_s;
            exit_error_q   <= exit_rise_s && !dep_ok_s;
        end
    end

    assign occupancy    = occupancy_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign entry_reject = entry_reject_q;
    assign exit_error   = exit_error_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl (CAPACITY=3, GATE_HOLD_CYCLES=8)
// using an event/timer reference model plus directed scenario checks.
module tb_parking_gate_ctrl;

    localparam int CAP  = 3;
    localparam int HOLD = 8;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          entry_sensor = 1'b0;
    logic          exit_sensor = 1'b0;
    logic [CW-1:0] occupancy;
    logic          full, empty, entry_gate_open, exit_gate_open, entry_reject, exit_error;

    int tests_run = 0;
    int tests_failed = 0;

    parking_gate_ctrl #(
        .CAPACITY         (CAP),
        .COUNT_W          (CW),
        .GATE_HOLD_CYCLES (HOLD)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .entry_sensor    (entry_sensor),
        .exit_sensor     (exit_sensor),
        .occupancy       (occupancy),
        .full            (full),
        .empty           (empty),
        .entry_gate_open (entry_gate_open),
        .exit_gate_open  (exit_gate_open),
        .entry_reject    (entry_reject),
        .exit_error      (exit_error)
    );

    always #5 clk = ~clk;

    // Reference model: a car count plus, per barrier, "open" and the edge index it closes at.
    int   cyc = 0;
    int   m_occ = 0;
    logic m_prev_e = 1'b0, m_prev_x = 1'b0;
    logic m_rej = 1'b0, m_err = 1'b0;
    logic m_e_open = 1'b0, m_x_open = 1'b0;
    int   m_e_close = -1, m_x_close = -1;

    wire [9:0] dut_vec = {occupancy, full, empty, entry_gate_open, exit_gate_open,
                          entry_reject, exit_error};

    function automatic logic [9:0] exp_vec();
        logic [CW-1:0] o;
        o = CW'(m_occ);
        return {o, (m_occ == CAP), (m_occ == 0), m_e_open, m_x_open, m_rej, m_err};
    endfunction

    task automatic model_gate(input logic accepted, input logic level,
                              inout logic open, inout int close_at);
        if (accepted) begin
            open = 1'b1;
            close_at = -1;
        end else if (open && close_at < 0 && !level) begin
            close_at = cyc + HOLD;
        end else if (open && close_at >= 0 && cyc >= close_at) begin
            open = 1'b0;
        end
    endtask

    task automatic model_edge(input logic e, input logic x, input logic r);
        logic arr, dep, a_ok, d_ok;
        if (r) begin
            m_occ = 0; m_rej = 1'b0; m_err = 1'b0;
            m_e_open = 1'b0; m_x_open = 1'b0; m_e_close = -1; m_x_close = -1;
        end else begin
            arr  = e && !m_prev_e;
            dep  = x && !m_prev_x;
            a_ok = arr && (m_occ < CAP);
            d_ok = dep && (m_occ > 0);
            m_rej = arr && !a_ok;
            m_err = dep && !d_ok;
            m_occ = m_occ + (a_ok ? 1 : 0) - (d_ok ? 1 : 0);
            model_gate(a_ok, e, m_e_open, m_e_close);
            model_gate(d_ok, x, m_x_open, m_x_close);
        end
        m_prev_e = e;
        m_prev_x = x;
    endtask

    // Drive one cycle from a negedge, update the model at the posedge, return at the next negedge.
    task automatic step(input logic e, input logic x, input logic r);
        entry_sensor = e;
        exit_sensor  = x;
        reset        = r;
        @(posedge clk);
        cyc++;
        model_edge(e, x, r);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        tests_run++;
        if (dut_vec !== 10'b0000_0_1_0_0_0_0) begin
            tests_failed++;
            $display("FAIL reset_values: got %b expected %b", dut_vec, 10'b0000_0_1_0_0_0_0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0);
            tests_run++;
            if (occupancy !== 4'd0 || empty !== 1'b1 || entry_gate_open !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_high_sensor: got occ=%0d empty=%b gate=%b expected 0 1 0",
                         occupancy, empty, entry_gate_open);
            end
        end
    endtask

    task automatic test_single_car();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0);
            tests_run++;
            if (occupancy !== 4'd1 || entry_gate_open !== 1'b1) begin
                tests_failed++;
                $display("FAIL single_open[%0d]: got occ=%0d gate=%b expected 1 1", i, occupancy, entry_gate_open);
            end
        end
        for (int i = 1; i <= HOLD + 1; i++) begin
            step(1'b0, 1'b0, 1'b0);
            tests_run++;
            if (entry_gate_open !== (i <= HOLD) || dut_vec !== exp_vec()) begin
                tests_failed++;
                $display("FAIL single_hold[%0d]: got gate=%b vec=%b expected gate=%b vec=%b",
                         i, entry_gate_open, dut_vec, (i <= HOLD), exp_vec());
            end
        end
    endtask

    task automatic test_fill();
        for (int c = 0; c < 2; c++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0);
            for (int i = 0; i < HOLD + 2; i++) step(1'b0, 1'b0, 1'b0);
        end
        tests_run++;
        if (occupancy !== 4'd3 || full !== 1'b1 || empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_full: got occ=%0d full=%b empty=%b expected 3 1 0", occupancy, full, empty);
        end
        step(1'b1, 1'b0, 1'b0);
        tests_run++;
        if (entry_reject !== 1'b1 || entry_gate_open !== 1'b0 || occupancy !== 4'd3) begin
            tests_failed++;
            $display("FAIL fill_reject: got rej=%b gate=%b occ=%0d expected 1 0 3",
                     entry_reject, entry_gate_open, occupancy);
        end
        step(1'b1, 1'b0, 1'b0);
        tests_run++;
        if (entry_reject !== 1'b0 || entry_gate_open !== 1'b0 || occupancy !== 4'd3) begin
            tests_failed++;
            $display("FAIL fill_reject_pulse: got rej=%b gate=%b occ=%0d expected 0 0 3",
                     entry_reject, entry_gate_open, occupancy);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_full_simultaneous();
        step(1'b1, 1'b1, 1'b0);
        tests_run++;
        if (entry_reject !== 1'b1 || occupancy !== 4'd2 || exit_gate_open !== 1'b1 || full !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_simul: got rej=%b occ=%0d xgate=%b full=%b expected 1 2 1 0",
                     entry_reject, occupancy, exit_gate_open, full);
        end
        for (int i = 0; i < HOLD + 2; i++) step(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            step(1'b0, 1'b1, 1'b0);
            for (int i = 0; i < HOLD + 2; i++) step(1'b0, 1'b0, 1'b0);
        end
        tests_run++;
        if (occupancy !== 4'd0 || empty !== 1'b1 || exit_gate_open !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain_empty: got occ=%0d empty=%b xgate=%b expected 0 1 0",
                     occupancy, empty, exit_gate_open);
        end
    endtask

    task automatic test_empty_departure();
        step(1'b0, 1'b1, 1'b0);
        tests_run++;
        if (exit_error !== 1'b1 || occupancy !== 4'd0 || exit_gate_open !== 1'b0) begin
            tests_failed++;
            $display("FAIL empty_departure: got err=%b occ=%0d xgate=%b expected 1 0 0",
                     exit_error, occupancy, exit_gate_open);
        end
        step(1'b0, 1'b1, 1'b0);
        tests_run++;
        if (exit_error !== 1'b0 || exit_gate_open !== 1'b0) begin
            tests_failed++;
            $display("FAIL empty_error_pulse: got err=%b xgate=%b expected 0 0", exit_error, exit_gate_open);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_hold_reentry();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        tests_run++;
        if (occupancy !== 4'd2 || entry_gate_open !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_reentry: got occ=%0d gate=%b expected 2 1", occupancy, entry_gate_open);
        end
        for (int i = 0; i < HOLD; i++) begin
            step(1'b0, 1'b0, 1'b0);
            tests_run++;
            if (entry_gate_open !== 1'b1) begin
                tests_failed++;
                $display("FAIL hold_reentry_open[%0d]: got gate=%b expected 1", i, entry_gate_open);
            end
        end
        step(1'b0, 1'b0, 1'b1);
        tests_run++;
        if (dut_vec !== 10'b0000_0_1_0_0_0_0) begin
            tests_failed++;
            $display("FAIL reset_mid_hold: got %b expected %b", dut_vec, 10'b0000_0_1_0_0_0_0);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic e_lvl = 1'b0, x_lvl = 1'b0, rst;
        int   e_left = 0, x_left = 0;
        for (int i = 0; i < 800; i++) begin
            if (e_left == 0) begin e_lvl = ~e_lvl; e_left = $urandom_range(1, 12); end
            if (x_left == 0) begin x_lvl = ~x_lvl; x_left = $urandom_range(1, 14); end
            e_left--;
            x_left--;
            rst = ($urandom_range(0, 199) == 0);
            step(e_lvl, x_lvl, rst);
            tests_run++;
            if (dut_vec !== exp_vec()) begin
                tests_failed++;
                $display("FAIL random[%0d]: got {occ,full,empty,eg,xg,rej,err}=%b expected %b",
                         i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_car();
        test_fill();
        test_full_simultaneous();
        test_empty_departure();
        test_hold_reentry();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
